// File: rtl/display_scan_mux.sv
// display_scan_mux
//   Time-multiplexed selector for the seven-segment display path. It picks one
//   WIDTH-bit digit out of CHANNELS packed inputs. The digit is chosen either
//   manually through sel, or by a prescaled scan counter that rotates through
//   the channels. All outputs are registered, so y, digit_en and ch always
//   change together.
//
//   Parameters: WIDTH (bits per channel), CHANNELS (>=2),
//               SEL_W (2**SEL_W >= CHANNELS), PRESCALE (clocks per scan step, >=1)
//   Ports:
//     clk      in   rising-edge system clock
//     rst      in   asynchronous active-high reset
//     data_in  in   packed channels, channel k = data_in[k*WIDTH +: WIDTH]
//     mode     in   1 = auto scan, 0 = manual select
//     sel      in   manual channel index (an out-of-range value is ignored)
//     hold     in   auto mode: freeze the scan index
//     y        out  selected channel value (registered)
//     digit_en out  one-hot enable of the displayed channel (registered)
//     ch       out  current channel index
//     tick     out  one-cycle pulse at the prescaler terminal count
//   Build option: define SCAN_BLANK_EN to blank digit_en for one clock on
//   every index change (anti-ghosting).
module display_scan_mux #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned PRESCALE = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      hold,
  output logic [WIDTH-1:0]          y,
  output logic [CHANNELS-1:0]       digit_en,
  output logic [SEL_W-1:0]          ch,
  output logic                      tick
);

  localparam int unsigned PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PC_W-1:0]  PC_LAST = PC_W'(PRESCALE - 1);
  localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CHANNELS - 1);
  // One extra bit so CHANNELS == 2**SEL_W is still representable.
  localparam logic [SEL_W:0]   CH_COUNT = (SEL_W + 1)'(CHANNELS);

  logic [PC_W-1:0]     pc;
  logic [SEL_W-1:0]    ch_nxt;
  logic [WIDTH-1:0]    y_nxt;
  logic [CHANNELS-1:0] onehot_nxt;

  assign tick = (pc == PC_LAST);

  // Prescaler free-runs in every mode, hold included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (tick) begin
      pc <= '0;
    end else begin
      pc <= pc + PC_W'(1);
    end
  end

  always_comb begin
    ch_nxt = ch;
    if (mode) begin
      if (tick && !hold) begin
        ch_nxt = (ch == CH_LAST) ? '0 : ch + SEL_W'(1);
      end
    end else if ({1'b0, sel} < CH_COUNT) begin
      ch_nxt = sel;
    end
  end

  // Compare-and-select instead of a variable part-select keeps unused
  // index codes (CHANNELS < 2**SEL_W) from addressing past data_in.
  always_comb begin
    y_nxt      = '0;
    onehot_nxt = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (ch_nxt == SEL_W'(k)) begin
        y_nxt         = data_in[k*WIDTH +: WIDTH];
        onehot_nxt[k] = 1'b1;
      end
    end
  end

`ifdef SCAN_BLANK_EN
  logic blank;
  logic blank_nxt;
  logic [CHANNELS-1:0] onehot_cur;

  assign blank_nxt = (ch_nxt != ch);

  always_comb begin
    onehot_cur = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (ch == SEL_W'(k)) begin
        onehot_cur[k] = 1'b1;
      end
    end
  end

  // The edge that changes the index loads all-off; the following edge
  // lights the (now settled) current channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch       <= '0;
      y        <= '0;
      digit_en <= '0;
      blank    <= 1'b0;
    end else begin
      ch       <= ch_nxt;
      y        <= y_nxt;
      blank    <= blank_nxt;
      if (blank_nxt) begin
        digit_en <= '0;
      end else if (blank) begin
        digit_en <= onehot_cur;
      end else begin
        digit_en <= onehot_nxt;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch       <= '0;
      y        <= '0;
      digit_en <= '0;
    end else begin
      ch       <= ch_nxt;
      y        <= y_nxt;
      digit_en <= onehot_nxt;
    end
  end
`endif

endmodule

// File: doc/display_scan_mux.md
# display_scan_mux

Parametrised, time-multiplexed channel selector for the seven-segment display path. It selects one WIDTH-bit digit out of CHANNELS packed inputs. Selection is either manual (select port) or automatic: a prescaled scan counter rotates through the channels and drives a one-hot digit enable. All outputs are registered, so the digit value and its enable always change on the same clock edge. The block sits between the timer/BCD logic and the segment decoder, in place of the fixed 4×4 combinational selector.

## Interface
- WIDTH, 4: bits per channel.
- CHANNELS, 4: number of channels; must be ≥2.
- SEL_W, 2: select/index width; must satisfy 2^SEL_W ≥ CHANNELS.
- PRESCALE, 1000: clocks per scan step; must be ≥1.
- clk  in  1  single system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  CHANNELS*WIDTH  packed channels; channel k is data_in[k*WIDTH +: WIDTH].
- mode  in  1  1 = auto scan, 0 = manual select.
- sel  in  SEL_W  manual channel index.
- hold  in  1  auto mode only: freezes the scan index.
- y  out  WIDTH  selected channel value, registered.
- digit_en  out  CHANNELS  one-hot enable for the displayed channel, registered.
- ch  out  SEL_W  current channel index.
- tick  out  1  one-cycle pulse at the prescaler terminal count.

## Operation
- Prescaler pc counts 0..PRESCALE-1 and wraps to 0.
  - It free-runs in every mode, including while hold is asserted.
  - tick = 1 exactly in the cycles where pc == PRESCALE-1, combinationally decoded from the pc register.
- Next index ch_nxt:
  - auto mode, tick, !hold: ch+1, wrapping from CHANNELS-1 to 0.
  - auto mode otherwise: ch.
  - manual mode: sel if sel < CHANNELS; otherwise ch (an out-of-range sel is ignored and the index holds).
- Every clock:
  - ch <= ch_nxt
  - y <= channel ch_nxt of data_in
  - digit_en <= one-hot(ch_nxt)
- Consequences:
  - y, digit_en and ch always describe the same channel.
  - y follows changes on data_in even while the index is static.
- Mode changes take effect at the next edge. Manual→auto resumes scanning from the current ch; the prescaler phase is not reset.
- Reset values: pc=0, ch=0, y=0, digit_en=0 (all digits off). Reset asserted mid-scan clears all of these immediately, without waiting for a clock.

## Timing
- Latency: 1 clock from data_in, sel or mode to y, digit_en and ch.
- Scan period: each channel is displayed for PRESCALE clocks. A full rotation takes CHANNELS*PRESCALE clocks.
- With PRESCALE=1, tick is constantly 1 and the index advances every clock.
- After reset release, the first edge loads ch=0, digit_en=one-hot(0) and y=channel 0. The first index advance occurs on the edge where pc == PRESCALE-1.
- Simultaneous hold and tick: hold wins; the index does not advance and the tick is lost, not deferred.
- Manual mode with a changing sel: the newest in-range sel is used each clock; no debouncing is performed.

## Configuration
- SCAN_BLANK_EN defined: anti-ghosting blanking.
  - On every edge where ch_nxt ≠ ch, digit_en is loaded with all zeros instead of the one-hot value. y and ch still update on that edge.
  - On the following edge, digit_en becomes one-hot(ch).
  - Implemented with a 1-bit blank register, which is cleared by reset.
  - Each channel is lit for PRESCALE-1 clocks per auto step.
- SCAN_BLANK_EN undefined: digit_en switches directly between one-hot values, as described in Operation.

## Test plan
Unless stated otherwise: WIDTH=4, CHANNELS=4, SEL_W=2, PRESCALE=4, data_in=16'hDCBA, SCAN_BLANK_EN undefined.
- Reset: hold rst=1 -> y=0, digit_en=0000, ch=0, tick=0. Release rst -> after the first edge y=A, digit_en=0001.
- Auto scan (mode=1, hold=0):
  - y steps A,B,C,D,A, each held 4 clocks.
  - digit_en steps 0001,0010,0100,1000,0001.
  - tick pulses every 4th clock, aligned with the cycle before each advance.
- Hold: assert hold while ch=2 -> ch stays 2 across 3 ticks. Change channel 2 to 4'h7 -> y=7 one clock later. Deassert hold -> next tick advances to ch=3.
- Manual: mode=0, sel=3 -> next edge y=D, digit_en=1000. Then sel=1 -> y=B, digit_en=0010. Rerun with CHANNELS=3 and sel=3 -> ch holds its previous value.
- Reset mid-scan: assert rst asynchronously while ch=3 -> y, digit_en and ch go to 0 before the next clock edge.
- SCAN_BLANK_EN defined, auto mode -> at each index change digit_en=0000 for exactly 1 clock, then one-hot for 3 clocks.
